// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default slot width, word-select polarity and the stereo sample layout.
package i2s_pkg;

    localparam int unsigned DEFAULT_NUMBER_OF_BITS = 8;

    typedef enum logic {
        WS_LEFT  = 1'b0,
        WS_RIGHT = 1'b1
    } ws_t;

    typedef struct packed {
        logic [DEFAULT_NUMBER_OF_BITS-1:0] left;
        logic [DEFAULT_NUMBER_OF_BITS-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_sck_divider.sv
// Serial bit clock generator: sck toggles every CLK_DIV system clocks, with edge ticks
// flagging the cycle on which sck is about to rise or fall.
module i2s_sck_divider #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic sck,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          toggle;

    assign toggle    = (div_cnt == DIV_LAST);
    assign fall_tick = toggle & sck;
    assign rise_tick = toggle & ~sck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (toggle) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pcm_to_i2s.sv
// Philips I2S transmitter: one-entry holding register feeding a 2N-bit frame shifted out
// MSB first on sck falling edges, with ws leading each channel by one bit.
module pcm_to_i2s
    import i2s_pkg::*;
#(
    parameter int unsigned NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS,
    parameter int unsigned CLK_DIV        = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUMBER_OF_BITS-1:0] left_in,
    input  logic [NUMBER_OF_BITS-1:0] right_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun
);

    localparam int unsigned N   = NUMBER_OF_BITS;
    localparam int unsigned FW  = 2 * N;
    localparam int unsigned FCW = $clog2(FW);
    localparam logic [FCW-1:0] FC_LAST  = FCW'(FW - 1);
    localparam logic [FCW-1:0] WS_FIRST = FCW'(N - 1);
    localparam logic [FCW-1:0] WS_LAST  = FCW'(FW - 2);

    logic           fall_tick;
    logic           rise_tick_unused;
    logic [FCW-1:0] fc;
    logic [FCW-1:0] fc_next;
    logic [FCW-1:0] bit_idx;
    logic [FW-1:0]  frame_word;
    logic [FW-1:0]  next_word;
    logic [FW-1:0]  hold_word;
    logic           hold_full;
    logic           frame_load;
    logic           sd_q;
    ws_t            ws_q;
    logic           underrun_q;

    i2s_sck_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_divider (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .fall_tick(fall_tick),
        .rise_tick(rise_tick_unused)
    );

    // The bit driven on a falling tick comes from the word in effect after that tick,
    // so a freshly loaded frame puts its left MSB on sd in the same cycle.
    always_comb begin
        fc_next    = (fc == FC_LAST) ? '0 : fc + 1'b1;
        frame_load = fall_tick && (fc == FC_LAST);
        next_word  = frame_word;
        if (frame_load) begin
            next_word = hold_full ? hold_word : '0;
        end
        bit_idx = FC_LAST - fc_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc         <= FC_LAST;
            frame_word <= '0;
            hold_word  <= '0;
            hold_full  <= 1'b0;
            sd_q       <= 1'b0;
            ws_q       <= WS_LEFT;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (fall_tick) begin
                fc         <= fc_next;
                frame_word <= next_word;
                sd_q       <= next_word[bit_idx];
                ws_q       <= (fc_next >= WS_FIRST && fc_next <= WS_LAST) ? WS_RIGHT : WS_LEFT;
                if (frame_load && !hold_full) begin
                    underrun_q <= 1'b1;
                end
            end
            // Accept only into an empty register; a load in the same cycle saw it empty.
            if (in_valid && !hold_full) begin
                hold_word <= {left_in, right_in};
                hold_full <= 1'b1;
            end else if (frame_load) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign in_ready = ~hold_full;
    assign sd       = sd_q;
    assign ws       = ws_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// Self-checking bench for pcm_to_i2s: frame-level reference model checked every cycle,
// a constant vector table for one known frame, and hand sequences for the corner cases.
module tb_pcm_to_i2s;

    localparam int N     = 8;
    localparam int D     = 2;
    localparam int FRAME = 4 * N * D;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] left_in = '0;
    logic [N-1:0] right_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, sck, ws, sd, underrun;

    logic [N-1:0] f_zero = '0;
    logic         f_valid = 1'b0;
    logic         f_in_ready, f_sck, f_ws, f_sd, f_underrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pcm_to_i2s #(.NUMBER_OF_BITS(N), .CLK_DIV(D)) dut (
        .clk(clk), .reset(reset), .left_in(left_in), .right_in(right_in),
        .in_valid(in_valid), .in_ready(in_ready), .sck(sck), .ws(ws), .sd(sd),
        .underrun(underrun)
    );

    pcm_to_i2s #(.NUMBER_OF_BITS(N), .CLK_DIV(1)) dut_fast (
        .clk(clk), .reset(reset), .left_in(f_zero), .right_in(f_zero),
        .in_valid(f_valid), .in_ready(f_in_ready), .sck(f_sck), .ws(f_ws), .sd(f_sd),
        .underrun(f_underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: e counts clk edges since reset; frames load at e = 2D + k*FRAME.
    int           e = 0;
    logic         m_pending = 1'b0;
    logic [2*N-1:0] m_hold = '0;
    logic [2*N-1:0] m_word = '0;
    logic         m_under = 1'b0;
    logic         m_accept;

    always @(posedge clk) begin
        if (reset) begin
            e = 0; m_pending = 1'b0; m_hold = '0; m_word = '0; m_under = 1'b0;
        end else begin
            m_accept = in_valid && !m_pending;
            e = e + 1;
            m_under = 1'b0;
            if (e >= 2 * D && (e - 2 * D) % FRAME == 0) begin
                if (m_pending) begin
                    m_word = m_hold;
                    m_pending = 1'b0;
                end else begin
                    m_word = '0;
                    m_under = 1'b1;
                end
            end
            if (m_accept) begin
                m_hold = {left_in, right_in};
                m_pending = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        int k;
        int f;
        logic esd, ews, esck;
        #3;
        if (reset) begin
            check("rst_sck", sck, 0);
            check("rst_ws", ws, 0);
            check("rst_sd", sd, 0);
            check("rst_ready", in_ready, 1);
            check("rst_underrun", underrun, 0);
        end else begin
            k = e / (2 * D);
            esck = ((e / D) % 2) == 1;
            if (k == 0) begin
                f = 2 * N - 1;
                esd = 1'b0;
            end else begin
                f = (k - 1) % (2 * N);
                esd = m_word[2 * N - 1 - f];
            end
            ews = (k != 0) && (f >= N - 1) && (f <= 2 * N - 2);
            check("model_sck", sck, esck);
            check("model_ws", ws, ews);
            check("model_sd", sd, esd);
            check("model_ready", in_ready, !m_pending);
            check("model_underrun", underrun, m_under);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic sd;
        logic ws;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [15:0] sd_bits;
        logic [15:0] ws_bits;
        logic [N-1:0] seq;
        logic [N-1:0] col_l;
        logic         rdy, prev_rdy;
        int           cnt_under, cnt_sd, rises, guard, gap, bad_toggle;
        logic         prev_sck;

        sd_bits = 16'b1010_0101_0011_1100;
        ws_bits = 16'b0000_0001_1111_1110;
        for (int i = 0; i < 16; i++) begin
            tbl[i].sd = sd_bits[15 - i];
            tbl[i].ws = ws_bits[15 - i];
        end

        // Reset held three cycles, then a known pair accepted before the first falling tick.
        step(3);
        reset = 1'b0;
        in_valid = 1'b1;
        left_in = 8'hA5;
        right_in = 8'h3C;
        step(1);
        in_valid = 1'b0;
        check("accept_ready_low", in_ready, 0);
        check("edge1_sck", sck, 0);
        step(1);
        check("first_rise_sck", sck, 1);
        step(2);
        check("first_fall_sck", sck, 0);
        check("first_load_underrun", underrun, 0);
        check("first_load_ready", in_ready, 1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step(4);
            check($sformatf("frame_sd_f%0d", i), sd, tbl[i].sd);
            check($sformatf("frame_ws_f%0d", i), ws, tbl[i].ws);
        end
        step(4);
        check("empty_frame_underrun", underrun, 1);
        check("empty_frame_sd", sd, 0);

        // Idle: one underrun per frame, sd silent.
        cnt_under = 0;
        cnt_sd = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1);
            if (underrun) cnt_under++;
            if (sd) cnt_sd++;
        end
        check("idle_underrun_count", cnt_under, 3);
        check("idle_sd_ones", cnt_sd, 0);

        // Backpressure: continuous valid with an incrementing pattern.
        seq = N'($urandom);
        in_valid = 1'b1;
        left_in = seq;
        right_in = seq ^ 8'h5A;
        rises = 0;
        cnt_under = 0;
        prev_rdy = in_ready;
        for (int i = 0; i < 5 * FRAME; i++) begin
            rdy = in_ready;
            step(1);
            if (rdy) begin
                seq = seq + 1'b1;
                left_in = seq;
                right_in = seq ^ 8'h5A;
            end
            if (underrun) cnt_under++;
            if (i >= FRAME) begin
                if (in_ready && !prev_rdy) rises++;
            end
            prev_rdy = in_ready;
        end
        in_valid = 1'b0;
        check("bp_ready_rises", rises, 4);
        check("bp_no_underrun", cnt_under, 0);
        step(2 * FRAME);

        // Load collision: accept lands on the load edge with the register empty.
        guard = 0;
        while (((e + 1 - 2 * D) % FRAME) != 0 && guard < 200) begin
            step(1);
            guard++;
        end
        check("collision_align", guard < 200, 1);
        col_l = N'($urandom) | 8'h80;
        in_valid = 1'b1;
        left_in = col_l;
        right_in = N'($urandom);
        step(1);
        in_valid = 1'b0;
        check("collision_underrun", underrun, 1);
        check("collision_held", in_ready, 0);
        check("collision_zero_sd", sd, 0);
        step(FRAME);
        check("collision_next_underrun", underrun, 0);
        check("collision_next_ready", in_ready, 1);
        check("collision_next_msb", sd, col_l[N-1]);

        // Mid-frame reset at f = 5 with a pair pending: pair is discarded.
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check("pending_before_reset", in_ready, 0);
        guard = 0;
        while (!(e >= 2 * D && e % (2 * D) == 0 && ((e / (2 * D) - 1) % (2 * N)) == 5) && guard < 200) begin
            step(1);
            guard++;
        end
        check("f5_align", guard < 200, 1);
        step(1);
        reset = 1'b1;
        #1;
        check("midrst_sck", sck, 0);
        check("midrst_ws", ws, 0);
        check("midrst_sd", sd, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_underrun", underrun, 0);
        step(2);
        reset = 1'b0;
        step(2);
        check("rerst_rise", sck, 1);
        step(2);
        check("rerst_fall", sck, 0);
        check("rerst_discarded_underrun", underrun, 1);

        // CLK_DIV = 1: sck toggles every cycle, underrun every 32 cycles.
        guard = 0;
        while (!f_underrun && guard < 100) begin
            step(1);
            guard++;
        end
        check("fast_first_underrun", f_underrun, 1);
        gap = 0;
        bad_toggle = 0;
        prev_sck = f_sck;
        do begin
            step(1);
            gap++;
            if (f_sck === prev_sck) bad_toggle++;
            prev_sck = f_sck;
        end while (!f_underrun && gap < 100);
        check("fast_frame_period", gap, 32);
        check("fast_sck_toggles", bad_toggle, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
